// File: rtl/data_mem_ctrl.sv
// Byte-wide RAM/IO port controller: arbitrates instruction fetches and LSB
// loads/stores, sequences the byte transfers and assembles extended load data.
module data_mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11,
  parameter int         ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  output logic [31:0]       inst_out,
  input  logic              need_data,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_in,
  input  logic [2:0]        work_type,
  output logic              data_handle,
  output logic              data_ready,
  output logic [31:0]       data_out
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t              state_r;
  logic [2:0]          cnt_r;
  logic [2:0]          len_r;
  logic [2:0]          type_r;
  logic [23:0]         wdata_r;
  logic [31:0]         buf_r;
  logic                last_data_r;
  logic [ADDR_W-1:0]   mem_a_r;
  logic [7:0]          mem_dout_r;
  logic                mem_wr_r;
  logic                inst_ready_r;
  logic [31:0]         inst_out_r;
  logic                data_ready_r;
  logic [31:0]         data_out_r;

  logic                lsb_ok_s;
  logic                fetch_ok_s;
  logic                grant_fetch_s;
  logic                grant_data_s;
  logic [1:0]          bidx_s;
  logic [31:0]         word_s;

  function automatic logic [2:0] len_of(input logic [1:0] wt);
    case (wt)
      2'b00:   len_of = 3'd1;
      2'b01:   len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] wt, input logic [31:0] w);
    case (wt)
      3'b000:  extend_load = {{24{w[7]}}, w[7:0]};
      3'b001:  extend_load = {{16{w[15]}}, w[15:0]};
      3'b100:  extend_load = {24'd0, w[7:0]};
      3'b101:  extend_load = {16'd0, w[15:0]};
      default: extend_load = w;
    endcase
  endfunction

  // Eligibility and round-robin grant, only while idle and enabled
  always_comb begin
    lsb_ok_s      = need_data
                    && !(is_write && (data_addr[17:16] == IO_SEL) && io_buffer_full)
                    && !(!is_write && rob_clear);
    fetch_ok_s    = inst_req && !rob_clear;
    grant_fetch_s = 1'b0;
    grant_data_s  = 1'b0;
    if (rdy_in && (state_r == IDLE)) begin
      if (lsb_ok_s && fetch_ok_s) begin
        grant_fetch_s = last_data_r;
        grant_data_s  = !last_data_r;
      end else begin
        grant_fetch_s = fetch_ok_s;
        grant_data_s  = lsb_ok_s;
      end
    end else begin
      grant_fetch_s = 1'b0;
      grant_data_s  = 1'b0;
    end
  end

  // Merge the byte arriving this cycle (index cnt-1) into the partial word
  always_comb begin
    bidx_s = cnt_r[1:0] - 2'd1;
    word_s = buf_r;
    if (cnt_r != 3'd0) begin
      word_s[{bidx_s, 3'b000} +: 8] = mem_din;
    end else begin
      word_s = buf_r;
    end
  end

  assign data_handle = grant_data_s;
  assign mem_wr      = mem_wr_r & rdy_in;
  assign mem_a       = mem_a_r;
  assign mem_dout    = mem_dout_r;
  assign inst_ready  = inst_ready_r;
  assign inst_out    = inst_out_r;
  assign data_ready  = data_ready_r;
  assign data_out    = data_out_r;

  // Transaction sequencer; cnt counts issued cycles, byte cnt-1 lands each read cycle
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      len_r        <= 3'd0;
      type_r       <= 3'd0;
      wdata_r      <= 24'd0;
      buf_r        <= 32'd0;
      last_data_r  <= 1'b1;
      mem_a_r      <= '0;
      mem_dout_r   <= 8'd0;
      mem_wr_r     <= 1'b0;
      inst_ready_r <= 1'b0;
      inst_out_r   <= 32'd0;
      data_ready_r <= 1'b0;
      data_out_r   <= 32'd0;
    end else if (rdy_in) begin
      inst_ready_r <= 1'b0;
      data_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 3'd0;
          buf_r <= 32'd0;
          if (grant_fetch_s) begin
            state_r     <= FETCH;
            len_r       <= 3'd4;
            mem_a_r     <= inst_addr;
            last_data_r <= 1'b0;
          end else if (grant_data_s) begin
            last_data_r <= 1'b1;
            mem_a_r     <= data_addr;
            type_r      <= work_type;
            len_r       <= len_of(work_type[1:0]);
            if (is_write) begin
              state_r    <= STORE;
              mem_wr_r   <= 1'b1;
              mem_dout_r <= data_in[7:0];
              wdata_r    <= data_in[31:8];
            end else begin
              state_r <= LOAD;
            end
          end
        end
        FETCH, LOAD: begin
          if (rob_clear) begin
            state_r <= IDLE;
          end else begin
            buf_r <= word_s;
            if (cnt_r == len_r) begin
              state_r <= IDLE;
              if (state_r == FETCH) begin
                inst_ready_r <= 1'b1;
                inst_out_r   <= word_s;
              end else begin
                data_ready_r <= 1'b1;
                data_out_r   <= extend_load(type_r, word_s);
              end
            end else begin
              cnt_r <= cnt_r + 3'd1;
              if ((cnt_r + 3'd1) < len_r) begin
                mem_a_r <= mem_a_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        STORE: begin
          // Stores were already popped by the LSB, so rob_clear never cuts them short
          if ((cnt_r + 3'd1) < len_r) begin
            cnt_r      <= cnt_r + 3'd1;
            mem_a_r    <= mem_a_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_dout_r <= wdata_r[7:0];
            wdata_r    <= {8'd0, wdata_r[23:8]};
          end else begin
            mem_wr_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          mem_wr_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: table of load/store vectors plus
// hand sequences for aborts, IO back-pressure and fetch/load alternation.
module tb_data_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic        need_data, is_write;
  logic [31:0] data_addr, data_in;
  logic [2:0]  work_type;
  logic        data_handle, data_ready;
  logic [31:0] data_out;

  data_mem_ctrl #(.IO_SEL(2'b11), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .inst_out(inst_out), .need_data(need_data),
    .is_write(is_write), .data_addr(data_addr), .data_in(data_in),
    .work_type(work_type), .data_handle(data_handle), .data_ready(data_ready),
    .data_out(data_out)
  );

  typedef struct { logic [31:0] val; int cyc; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  wt;
    logic [31:0] din;
    logic        pre;
    logic [31:0] ram_word;
    logic [31:0] exp_v;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [7:0] ram [logic [31:0]];
  exp_t dq[$];
  exp_t iq[$];
  wr_t  wq[$];
  logic [7:0] order_q[$];
  exp_t mon_e;
  wr_t  mon_w;
  vec_t vecs [10];

  always #5 clk_in = ~clk_in;

  // Cycle counter and RAM model: read byte appears one cycle after its address
  always @(posedge clk_in) begin
    cyc     <= cyc + 1;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard: pops expectations when the DUT writes or signals completion
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (mem_wr) begin
        ram[mem_a] = mem_dout;
        if (wq.size() == 0) begin
          chk("unexpected_write", {31'd0, mem_wr}, 32'd0);
        end else begin
          mon_w = wq.pop_front();
          chk("wr_addr", mem_a, mon_w.a);
          chk("wr_data", {24'd0, mem_dout}, {24'd0, mon_w.d});
          chk("wr_cycle", cyc, mon_w.cyc);
        end
      end
      if (data_ready) begin
        order_q.push_back(8'h4C);
        if (dq.size() == 0) begin
          chk("unexpected_data_ready", {31'd0, data_ready}, 32'd0);
        end else begin
          mon_e = dq.pop_front();
          chk("data_out", data_out, mon_e.val);
          if (mon_e.cyc >= 0) chk("data_ready_cycle", cyc, mon_e.cyc);
        end
      end
      if (inst_ready) begin
        order_q.push_back(8'h46);
        if (iq.size() == 0) begin
          chk("unexpected_inst_ready", {31'd0, inst_ready}, 32'd0);
        end else begin
          mon_e = iq.pop_front();
          chk("inst_out", inst_out, mon_e.val);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    int  t;
    bit  got;
    wr_t w;
    exp_t e;
    n = (v.wt[1:0] == 2'b00) ? 1 : ((v.wt[1:0] == 2'b01) ? 2 : 4);
    if (v.pre) begin
      for (int k = 0; k < 4; k++) ram[32'(v.addr + k)] = v.ram_word[8*k +: 8];
    end
    tick();
    need_data = 1'b1; is_write = v.wr; data_addr = v.addr;
    data_in = v.din; work_type = v.wt;
    #1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (data_handle) begin
        got = 1'b1;
        break;
      end
      tick(); #1;
    end
    chk($sformatf("vec%0d_handle", idx), {31'd0, got}, 32'd1);
    t = cyc;
    if (v.wr) begin
      for (int k = 0; k < n; k++) begin
        w.a = 32'(v.addr + k); w.d = v.din[8*k +: 8]; w.cyc = t + 1 + k;
        wq.push_back(w);
      end
    end else begin
      e.val = v.exp_v; e.cyc = t + n + 2;
      dq.push_back(e);
    end
    tick(); need_data = 1'b0; #1;
    for (int j = 1; j <= n + 2; j++) begin
      if (!v.wr && j <= n) begin
        chk($sformatf("vec%0d_mem_a", idx), mem_a, 32'(v.addr + j - 1));
        chk($sformatf("vec%0d_rd_wr", idx), {31'd0, mem_wr}, 32'd0);
      end
      tick(); #1;
    end
    chk($sformatf("vec%0d_dq_drained", idx), dq.size(), 32'd0);
    chk($sformatf("vec%0d_wq_drained", idx), wq.size(), 32'd0);
  endtask

  initial begin
    int   t;
    exp_t e;
    wr_t  w;
    logic [7:0] exp_order [5];
    logic [31:0] sw_data;

    vecs[0] = '{1'b0, 32'h0000_0100, 3'b010, 32'h0, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{1'b0, 32'h0000_0080, 3'b000, 32'h0, 1'b1, 32'h0000_0080, 32'hFFFF_FF80};
    vecs[2] = '{1'b0, 32'h0000_0080, 3'b100, 32'h0, 1'b0, 32'h0,         32'h0000_0080};
    vecs[3] = '{1'b0, 32'h0000_0090, 3'b001, 32'h0, 1'b1, 32'h0000_FFFE, 32'hFFFF_FFFE};
    vecs[4] = '{1'b0, 32'h0000_0090, 3'b101, 32'h0, 1'b0, 32'h0,         32'h0000_FFFE};
    vecs[5] = '{1'b0, 32'h0000_0081, 3'b000, 32'h0, 1'b1, 32'h0000_007F, 32'h0000_007F};
    vecs[6] = '{1'b1, 32'hFFFF_FFFE, 3'b010, 32'hA1B2_C3D4, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFE, 3'b010, 32'h0, 1'b0, 32'h0,         32'hA1B2_C3D4};
    vecs[8] = '{1'b1, 32'h0000_0204, 3'b001, 32'h1234_ABCD, 1'b0, 32'h0, 32'h0};
    vecs[9] = '{1'b0, 32'h0000_0204, 3'b101, 32'h0, 1'b0, 32'h0,         32'h0000_ABCD};

    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h0; need_data = 1'b0; is_write = 1'b0;
    data_addr = 32'h0; data_in = 32'h0; work_type = 3'b000;
    repeat (3) tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_data_ready", {31'd0, data_ready}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    rst_in = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Load aborted by rob_clear in T+3; controller must be idle at T+4
    tick();
    need_data = 1'b1; is_write = 1'b0; data_addr = 32'h100; work_type = 3'b010;
    #1;
    chk("abort_ld_handle", {31'd0, data_handle}, 32'd1);
    t = cyc;
    tick(); need_data = 1'b0; #1;
    tick();
    tick(); rob_clear = 1'b1; #1;
    tick(); rob_clear = 1'b0;
    need_data = 1'b1; data_addr = 32'h80; work_type = 3'b100; #1;
    chk("abort_ld_idle_t4", {31'd0, data_handle}, 32'd1);
    chk("abort_ld_t4_cycle", cyc, 32'(t + 4));
    e.val = 32'h0000_0080; e.cyc = cyc + 3;
    dq.push_back(e);
    tick(); need_data = 1'b0; #1;
    repeat (6) tick();
    chk("abort_ld_dq_drained", dq.size(), 32'd0);

    // Store keeps writing through rob_clear
    sw_data = 32'hDEAD_BEEF;
    tick();
    need_data = 1'b1; is_write = 1'b1; data_addr = 32'h400; data_in = sw_data; work_type = 3'b010;
    #1;
    chk("abort_sw_handle", {31'd0, data_handle}, 32'd1);
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      w.a = 32'(32'h400 + k); w.d = sw_data[8*k +: 8]; w.cyc = t + 1 + k;
      wq.push_back(w);
    end
    tick(); need_data = 1'b0; #1;
    tick(); rob_clear = 1'b1; #1;
    tick(); rob_clear = 1'b0;
    repeat (5) tick();
    chk("abort_sw_wq_drained", wq.size(), 32'd0);

    // IO store held off while the IO buffer is full
    tick();
    need_data = 1'b1; is_write = 1'b1; data_addr = 32'h0003_0000; data_in = 32'h0000_005A;
    work_type = 3'b000; io_buffer_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("io_full_handle", {31'd0, data_handle}, 32'd0);
      chk("io_full_mem_wr", {31'd0, mem_wr}, 32'd0);
      tick(); #1;
    end
    io_buffer_full = 1'b0; #1;
    chk("io_release_handle", {31'd0, data_handle}, 32'd1);
    w.a = 32'h0003_0000; w.d = 8'h5A; w.cyc = cyc + 1;
    wq.push_back(w);
    tick(); need_data = 1'b0; #1;
    repeat (4) tick();
    chk("io_wq_drained", wq.size(), 32'd0);

    // Fetch and load requested together: grants alternate starting with fetch
    for (int k = 0; k < 4; k++) ram[32'(32'h1000 + k)] = 8'(32'h1357_9BDF >> (8*k));
    order_q.delete();
    for (int k = 0; k < 3; k++) begin e.val = 32'h1357_9BDF; e.cyc = -1; iq.push_back(e); end
    for (int k = 0; k < 2; k++) begin e.val = 32'h1234_5678; e.cyc = -1; dq.push_back(e); end
    tick();
    inst_addr = 32'h1000; inst_req = 1'b1;
    need_data = 1'b1; is_write = 1'b0; data_addr = 32'h100; work_type = 3'b010;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in); #1;
      if (order_q.size() >= 5) break;
    end
    inst_req = 1'b0; need_data = 1'b0;
    repeat (8) tick();
    exp_order[0] = 8'h46; exp_order[1] = 8'h4C; exp_order[2] = 8'h46;
    exp_order[3] = 8'h4C; exp_order[4] = 8'h46;
    chk("alt_count", order_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order_q.size()) chk($sformatf("alt_order%0d", i), {24'd0, order_q[i]}, {24'd0, exp_order[i]});
    end
    chk("alt_iq_drained", iq.size(), 32'd0);
    chk("alt_dq_drained", dq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory controller directly downstream of the load/store buffer and the instruction fetcher.
- Serves LSB load/store requests and 32-bit instruction fetches over the single byte-wide RAM/IO port: issues the byte sequences, assembles and sign/zero-extends load data, and applies the ROB-clear abort rules.
- One transaction in flight at a time. Round-robin arbitration when both the fetcher and the LSB request.

Parameters:
- IO_SEL, 2'b11: value of addr[17:16] that marks an IO address; IO stores are gated by io_buffer_full.
- ADDR_W, 32: address width of mem_a, data_addr and inst_addr.

Ports:
- clk_in  in  1  system clock; all state updates on posedge.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  when low: all state frozen, data_handle forced 0, mem_wr forced 0.
- rob_clear  in  1  misprediction flush.
- io_buffer_full  in  1  IO write buffer full.
- mem_din  in  8  RAM read byte; valid one cycle after its address is driven.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wr  out  1  1 = write.
- inst_req  in  1  fetch request; held until inst_ready.
- inst_addr  in  ADDR_W  fetch address, word aligned.
- inst_ready  out  1  one-cycle pulse; inst_out valid.
- inst_out  out  32  fetched word, little-endian.
- need_data  in  1  LSB request valid.
- is_write  in  1  1 = store.
- data_addr  in  ADDR_W  byte address.
- data_in  in  32  store data.
- work_type  in  3  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- data_handle  out  1  combinational accept pulse.
- data_ready  out  1  one-cycle load-done pulse.
- data_out  out  32  extended load data.

Behaviour:
- Reset: all outputs 0 (mem_a, mem_dout, mem_wr, inst_ready, inst_out, data_ready, data_out); state IDLE; byte counter 0; last_grant = data.
- States and transitions:
  - IDLE → FETCH, LOAD or STORE on a grant.
  - FETCH and LOAD → IDLE after the last byte, or on rob_clear.
  - STORE → IDLE after its last byte; never aborted.
- Byte count n: 1 for B/BU/SB, 2 for H/HU/SH, 4 for W/SW and for fetch.
- Grant rules (IDLE only):
  - LSB eligible when need_data is high, except:
    - not when is_write=1, data_addr[17:16]==IO_SEL and io_buffer_full=1;
    - not a load during a cycle with rob_clear=1.
  - Fetch eligible when inst_req=1 and rob_clear=0.
  - If both are eligible, grant the one not in last_grant, then update last_grant.
  - data_handle=1 exactly in the LSB grant cycle. Address, data_in and work_type are latched in that cycle.
- Load, granted in cycle T:
  - mem_a = addr+k in cycle T+1+k, for k in 0..n-1; mem_wr=0.
  - Byte k is captured from mem_din in cycle T+2+k.
  - data_ready=1 for exactly cycle T+n+2; data_out held until the next load.
  - Accepts the next request in cycle T+n+2.
  - Extension: B and H sign-extend; BU, HU and W zero-extend or pass through.
- Fetch: same timing as a word load; result on inst_out / inst_ready.
- Store, granted in cycle T:
  - In cycles T+1..T+n: mem_wr=1, mem_a=addr+k, mem_dout=data_in[8k+7:8k], little-endian.
  - mem_wr=0 in cycle T+n+1; IDLE then, so the next grant is possible in T+n+1.
- rob_clear:
  - During FETCH or LOAD: next edge returns to IDLE, mem_wr=0, no ready pulse, partial bytes discarded.
  - During STORE: ignored; the store completes. The LSB has already popped the store at data_handle.
- Address: mem_a increments without alignment checks; wraps modulo 2^ADDR_W.
- Outside active write cycles mem_wr=0. mem_a holds its last value while idle.

Test Plan:
- LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12, handle in cycle T → mem_a 0x100..0x103 in T+1..T+4; data_ready only in T+6 with data_out=0x12345678.
- LB at 0x80 with byte 0x80 → data_out=0xFFFFFF80. LBU at the same address → 0x00000080. LH reading 0xFE,0xFF → 0xFFFFFFFE.
- SH at 0x204, data_in=0x1234ABCD, handle in T → T+1: mem_wr=1, a=0x204, dout=0xCD; T+2: a=0x205, dout=0xAB; T+3: mem_wr=0.
- LW granted, rob_clear in T+3 → no data_ready; IDLE at T+4. SW with rob_clear in T+2 → all 4 byte writes still occur.
- inst_req and a load held continuously → grants alternate fetch, load, fetch; each completes with the correct word.
- SB to 0x30000 with io_buffer_full=1 for 5 cycles → data_handle=0 and mem_wr=0 throughout; handle asserted in the first cycle after full drops.
